// File: rtl/alu_pkg.sv
// Shared ALU definitions.
//   - mult_state_t : sequencer state of the shift-add multiplier
//   - ALU_WIDTH    : default operand width of the ALU datapath
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mult_state_t;

endpackage

// File: rtl/seq_mult_ctrl_adder.sv
// Ripple full-adder chain: sum = a + b + cin.
// Ports:
//   a, b   in  WIDTH  addends
//   cin    in  1      carry into bit 0
//   carry  out WIDTH  carry out of every bit position; carry[WIDTH-1] is the adder carry-out
//   sum    out WIDTH  sum bits
module seq_mult_ctrl_adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] carry,
  output logic [WIDTH-1:0] sum
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    logic c_in;
    if (i == 0) begin : g_lsb
      assign c_in = cin;
    end else begin : g_rest
      assign c_in = carry[i-1];
    end
    assign sum[i]   = a[i] ^ b[i] ^ c_in;
    assign carry[i] = (a[i] & b[i]) | (c_in & (a[i] ^ b[i]));
  end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential shift-add multiplier. One WIDTH-bit ripple adder is reused over
// WIDTH cycles to build an unsigned 2*WIDTH-bit product.
// Ports:
//   clk      in   1        rising-edge clock
//   rst      in   1        asynchronous active-high reset
//   start    in   1        request, accepted only while ready=1
//   abort    in   1        cancels an operation in RUN
//   a        in   WIDTH    multiplicand, sampled on accepted start
//   b        in   WIDTH    multiplier, sampled on accepted start
//   ready    out  1        IDLE or DONE
//   busy     out  1        RUN
//   done     out  1        one-cycle pulse when product has just been updated
//   product  out  2*WIDTH  last completed result
module seq_mult_ctrl
  import alu_pkg::*;
#(
  parameter  int WIDTH = ALU_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mult_state_t        state;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   add_carry;
  logic [WIDTH-1:0]   add_sum;
  logic [2*WIDTH-1:0] acc_next;

  // Partial sum lives in the upper half; the LSB of acc is the multiplier
  // bit being consumed this cycle.
  assign add_b = acc[0] ? mcand : '0;

  seq_mult_ctrl_adder #(.WIDTH(WIDTH)) u_adder (
    .a     (acc[2*WIDTH-1:WIDTH]),
    .b     (add_b),
    .cin   (1'b0),
    .carry (add_carry),
    .sum   (add_sum)
  );

  // Keeping the carry-out as the new MSB is what makes the product exact.
  assign acc_next = {add_carry[WIDTH-1], add_sum, acc[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= a;
            acc   <= {{WIDTH{1'b0}}, b};
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          // abort takes priority over the final iteration
          if (abort) begin
            state <= IDLE;
          end else begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              product <= acc_next;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          // start in DONE chains straight into the next operation
          if (start) begin
            mcand <= a;
            acc   <= {{WIDTH{1'b0}}, b};
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status is decoded from the state register only.
  assign ready = (state == IDLE) || (state == DONE);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_seq_mult_ctrl.sv
module tb_seq_mult_ctrl;

  localparam int W   = 16;
  localparam int LAT = W;   // edges from the accepting edge to the done cycle

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          ready;
  logic          busy;
  logic          done;
  logic [2*W-1:0] product;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2*W-1:0] last_result;   // model of the held product

  seq_mult_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    a     = x;
    b     = y;
    step();
    start = 1'b0;
  endtask

  // Steps until done is seen (bounded). cyc = edges stepped, -1 on timeout.
  task automatic wait_done(output int cyc, output int busy_cnt, output logic [2*W-1:0] p);
    cyc      = -1;
    busy_cnt = busy ? 1 : 0;
    p        = 'x;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (done) begin
        cyc = i;
        p   = product;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  // Counts done pulses over n cycles.
  task automatic count_done(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (done) pulses++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    n_checks++;
    if ({ready, busy, done} !== 3'b100 || product !== '0) begin
      n_fail++;
      $display("FAIL reset: rdy/busy/done=%b product=%h, required 100 / 0", {ready, busy, done}, product);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if ({ready, busy, done} !== 3'b100) begin
      n_fail++;
      $display("FAIL idle_after_reset: rdy/busy/done=%b, required 100", {ready, busy, done});
    end
    last_result = '0;
  endtask

  task automatic test_basic();
    int cyc, bc, pulses;
    logic [2*W-1:0] p;
    issue(16'd3, 16'd5);
    n_checks++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy: busy=%b ready=%b, required 1 0", busy, ready);
    end
    wait_done(cyc, bc, p);
    n_checks++;
    if (cyc !== LAT || bc !== W) begin
      n_fail++;
      $display("FAIL basic_latency: done after %0d, busy %0d cycles, required %0d / %0d", cyc, bc, LAT, W);
    end
    n_checks++;
    if (p !== 32'd15) begin
      n_fail++;
      $display("FAIL basic_product: got %h, required %h", p, 32'd15);
    end
    step();
    n_checks++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_pulse: done=%b ready=%b after pulse, required 0 1", done, ready);
    end
    last_result = 32'd15;
  endtask

  task automatic test_extremes();
    int cyc, bc;
    logic [2*W-1:0] p;
    issue(16'hFFFF, 16'hFFFF);
    wait_done(cyc, bc, p);
    n_checks++;
    if (p !== 32'hFFFE0001 || cyc !== LAT) begin
      n_fail++;
      $display("FAIL max_operands: product %h after %0d, required FFFE0001 after %0d", p, cyc, LAT);
    end
    step();
    issue(16'h1234, 16'h0000);
    wait_done(cyc, bc, p);
    n_checks++;
    if (p !== 32'd0 || cyc !== LAT) begin
      n_fail++;
      $display("FAIL zero_operand: product %h after %0d, required 0 after %0d", p, cyc, LAT);
    end
    step();
    last_result = '0;
  endtask

  task automatic test_ignored_start();
    int cyc, bc, pulses;
    logic [2*W-1:0] p;
    issue(16'd7, 16'd9);
    for (int i = 0; i < 4; i++) step();
    start = 1'b1; a = 16'd2; b = 16'd2;
    step();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL start_while_busy: busy=%b ready=%b, required 1 0", busy, ready);
    end
    wait_done(cyc, bc, p);
    n_checks++;
    if (p !== 32'd63 || cyc !== LAT - 5) begin
      n_fail++;
      $display("FAIL ignored_start_product: %h after %0d, required 3f after %0d", p, cyc, LAT - 5);
    end
    count_done(25, pulses);
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL ignored_start_pulses: %0d extra done pulses, required 0", pulses);
    end
    last_result = 32'd63;
  endtask

  task automatic test_abort();
    int cyc, bc, pulses;
    logic [2*W-1:0] p;
    issue(16'd100, 16'd200);
    for (int i = 0; i < 7; i++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_checks++;
    if ({ready, busy, done} !== 3'b100 || product !== last_result) begin
      n_fail++;
      $display("FAIL abort_mid: rdy/busy/done=%b product=%h, required 100 / %h", {ready, busy, done}, product, last_result);
    end
    count_done(25, pulses);
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL abort_no_done: %0d done pulses, required 0", pulses);
    end
    // abort on the final iteration still wins
    issue(16'd11, 16'd13);
    for (int i = 0; i < LAT - 1; i++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_checks++;
    if (done !== 1'b0 || ready !== 1'b1 || product !== last_result) begin
      n_fail++;
      $display("FAIL abort_last_cycle: done=%b ready=%b product=%h, required 0 1 %h", done, ready, product, last_result);
    end
    issue(16'd100, 16'd200);
    wait_done(cyc, bc, p);
    n_checks++;
    if (p !== 32'd20000 || cyc !== LAT) begin
      n_fail++;
      $display("FAIL after_abort: %0d after %0d, required 20000 after %0d", p, cyc, LAT);
    end
    step();
    last_result = 32'd20000;
  endtask

  task automatic test_back_to_back();
    int cyc, bc;
    logic [2*W-1:0] p;
    issue(16'd5, 16'd6);
    wait_done(cyc, bc, p);
    n_checks++;
    if (p !== 32'd30) begin
      n_fail++;
      $display("FAIL b2b_first: %h, required %h", p, 32'd30);
    end
    // in DONE: chain the next operation; distance between done pulses = LAT+1
    issue(16'h00FF, 16'h0100);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b, required 1", busy);
    end
    wait_done(cyc, bc, p);
    n_checks++;
    if (p !== 32'h0000FF00 || cyc + 1 !== LAT + 1) begin
      n_fail++;
      $display("FAIL b2b_second: %h, %0d cycles apart, required 0000ff00, %0d apart", p, cyc + 1, LAT + 1);
    end
    // start and abort together in DONE: start wins
    start = 1'b1; abort = 1'b1; a = 16'd3; b = 16'd4;
    step();
    start = 1'b0; abort = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL done_start_abort: busy=%b, required 1", busy);
    end
    wait_done(cyc, bc, p);
    n_checks++;
    if (p !== 32'd12 || cyc !== LAT) begin
      n_fail++;
      $display("FAIL done_start_abort_product: %0d after %0d, required 12 after %0d", p, cyc, LAT);
    end
    step();
    last_result = 32'd12;
  endtask

  task automatic test_async_reset();
    int pulses;
    issue(16'd1000, 16'd1000);
    for (int i = 0; i < 9; i++) step();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({ready, busy, done} !== 3'b100 || product !== '0) begin
      n_fail++;
      $display("FAIL async_reset: rdy/busy/done=%b product=%h, required 100 / 0", {ready, busy, done}, product);
    end
    #1 rst = 1'b0;
    count_done(25, pulses);
    n_checks++;
    if (pulses !== 0 || product !== '0) begin
      n_fail++;
      $display("FAIL async_reset_after: %0d pulses product=%h, required 0 / 0", pulses, product);
    end
    last_result = '0;
  endtask

  task automatic test_random();
    int cyc, bc, errs;
    logic [W-1:0] x, y;
    logic [2*W-1:0] p, exp;
    errs = 0;
    for (int n = 0; n < 1000; n++) begin
      x = W'($urandom);
      y = W'($urandom);
      if (n % 50 == 0) x = '1;
      exp = (2*W)'(x) * (2*W)'(y);
      issue(x, y);
      wait_done(cyc, bc, p);
      n_checks++;
      if (p !== exp || cyc !== LAT) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random %0d: %h*%h = %h after %0d, required %h after %0d", n, x, y, p, cyc, exp, LAT);
      end
      // sometimes chain straight from DONE, otherwise drop back to IDLE
      if ($urandom_range(1, 0) == 0) step();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; a = '0; b = '0;
    last_result = '0;
    test_reset();
    test_basic();
    test_extremes();
    test_ignored_start();
    test_abort();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
